// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, R/W bit values and default frame width for the SPI slave.
package spi_pkg;
   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      GET         = 4'd1,
      GOT         = 4'd2,
      READ_WAIT   = 4'd3,
      READ_LOAD   = 4'd4,
      READ_SEND   = 4'd5,
      WRITE_RECV  = 4'd6,
      WRITE_STORE = 4'd7,
      DONE        = 4'd8
   } state_t;
   localparam logic SPI_READ  = 1'b1;
   localparam logic SPI_WRITE = 1'b0;
   localparam int   SPI_WIDTH = 8;
   function automatic int cnt_bits(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/spi_if.sv
// spi_if: strobe/CS/R-W inputs and enable outputs of the SPI transaction controller.
interface spi_if import spi_pkg::*; #(parameter int width = SPI_WIDTH) ();
   logic sclkEdgeNeg;
   logic chipSelect;
   logic rwBit;
   logic addressLatchEnable;
   logic dataMemWriteEnable;
   logic parallelLoad;
   logic misoBufferEnable;
   logic busy;
   state_t state;
   logic [cnt_bits(width)-1:0] bitCount;
   modport master (
      output sclkEdgeNeg, chipSelect, rwBit,
      input  addressLatchEnable, dataMemWriteEnable, parallelLoad, misoBufferEnable, busy, state, bitCount
   );
   modport slave (
      input  sclkEdgeNeg, chipSelect, rwBit,
      output addressLatchEnable, dataMemWriteEnable, parallelLoad, misoBufferEnable, busy, state, bitCount
   );
endinterface

// File: rtl/spi_bitcounter.sv
// spi_bitcounter: counts serial bit strobes within one frame; clear wins over inc.
module spi_bitcounter import spi_pkg::*; #(
   parameter int width = SPI_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       inc,
   output logic [cnt_bits(width)-1:0] count,
   output logic                       last
);
   localparam int CW = cnt_bits(width);
   logic [CW-1:0] r_count;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_count <= '0;
      else if (clear) r_count <= '0;
      else if (inc) r_count <= r_count + 1'b1;
   end
   assign count = r_count;
   assign last  = r_count == CW'(width - 1);
endmodule

// File: rtl/spi_fsm.sv
// spi_fsm: SPI slave transaction controller; counts strobes, decodes R/W and
// issues registered (Moore) address-latch, write, load and MISO enables.
module spi_fsm import spi_pkg::*; #(
   parameter int width = SPI_WIDTH
) (
   input logic  clk,
   input logic  reset,
   spi_if.slave bus
);
   localparam int CW = cnt_bits(width);
   state_t r_state, w_next;
   logic r_ale, r_dmw, r_pl, r_miso, r_busy;
   logic w_strobe, w_inc, w_last, w_end;
   logic [CW-1:0] w_count;
   // CS high masks the strobe, so an aborting edge never counts or advances
   assign w_strobe = bus.sclkEdgeNeg && !bus.chipSelect;
   assign w_inc    = w_strobe && (r_state inside {GET, READ_SEND, WRITE_RECV});
   assign w_end    = w_inc && w_last;
   always_comb begin
      w_next = r_state;
      if (bus.chipSelect) w_next = IDLE;
      else begin
         case (r_state)
            IDLE:        w_next = GET;
            GET:         w_next = w_end ? GOT : GET;
            GOT:         w_next = (bus.rwBit == SPI_READ) ? READ_WAIT : WRITE_RECV;
            READ_WAIT:   w_next = READ_LOAD;
            READ_LOAD:   w_next = READ_SEND;
            READ_SEND:   w_next = w_end ? DONE : READ_SEND;
            WRITE_RECV:  w_next = w_end ? WRITE_STORE : WRITE_RECV;
            WRITE_STORE: w_next = DONE;
            DONE:        w_next = DONE;
            default:     w_next = IDLE;
         endcase
      end
   end
   spi_bitcounter #(.width(width)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (w_next != r_state),
      .inc   (w_inc),
      .count (w_count),
      .last  (w_last)
   );
   // outputs are decoded from the next state so they line up with the state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ale   <= 1'b0;
         r_dmw   <= 1'b0;
         r_pl    <= 1'b0;
         r_miso  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ale   <= w_next == GOT;
         r_dmw   <= w_next == WRITE_STORE;
         r_pl    <= w_next == READ_LOAD;
         r_miso  <= w_next == READ_SEND;
         r_busy  <= w_next != IDLE;
      end
   end
   assign bus.addressLatchEnable = r_ale;
   assign bus.dataMemWriteEnable = r_dmw;
   assign bus.parallelLoad       = r_pl;
   assign bus.misoBufferEnable   = r_miso;
   assign bus.busy               = r_busy;
   assign bus.state              = r_state;
   assign bus.bitCount           = w_count;
endmodule

// File: tb/tb_spi_fsm.sv
// tb_spi_fsm: directed scenarios for spi_fsm with hand-computed expectations.
module tb_spi_fsm;
   import spi_pkg::*;
   logic clk = 1'b0;
   logic reset;
   int checks = 0;
   int errors = 0;
   int ale_n, dmw_n, pl_n, miso_n;
   logic [3:0] en;
   spi_if #(.width(8)) bus ();
   spi_fsm #(.width(8)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign en = {bus.addressLatchEnable, bus.dataMemWriteEnable, bus.parallelLoad, bus.misoBufferEnable};

   task automatic clr_cnt();
      ale_n = 0; dmw_n = 0; pl_n = 0; miso_n = 0;
   endtask

   task automatic cyc(input logic s);
      bus.sclkEdgeNeg = s;
      @(posedge clk); #1;
      bus.sclkEdgeNeg = 1'b0;
      ale_n += int'(bus.addressLatchEnable);
      dmw_n += int'(bus.dataMemWriteEnable);
      pl_n += int'(bus.parallelLoad);
      miso_n += int'(bus.misoBufferEnable);
   endtask

   task automatic test_reset;
      checks++;
      if (bus.state !== IDLE || bus.bitCount !== 3'd0 || en !== 4'b0000 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: state=%0d cnt=%0d en=%b busy=%b, want 0 0 0000 0", bus.state, bus.bitCount, en, bus.busy);
      end
   endtask

   task automatic test_write;
      clr_cnt();
      bus.chipSelect = 1'b0;
      cyc(1'b0);
      checks++;
      if (bus.state !== GET || bus.busy !== 1'b1) begin
         errors++; $display("FAIL wr_enter_get: state=%0d busy=%b, want 1 1", bus.state, bus.busy);
      end
      repeat (7) cyc(1'b1);
      checks++;
      if (bus.bitCount !== 3'd7 || en !== 4'b0000) begin
         errors++; $display("FAIL wr_cmd_count: cnt=%0d en=%b, want 7 0000", bus.bitCount, en);
      end
      bus.rwBit = SPI_WRITE;
      cyc(1'b1);
      checks++;
      if (bus.state !== GOT || en !== 4'b1000) begin
         errors++; $display("FAIL wr_ale: state=%0d en=%b, want 2 1000", bus.state, en);
      end
      cyc(1'b0);
      checks++;
      if (bus.state !== WRITE_RECV || en !== 4'b0000 || bus.bitCount !== 3'd0) begin
         errors++; $display("FAIL wr_recv: state=%0d en=%b cnt=%0d, want 6 0000 0", bus.state, en, bus.bitCount);
      end
      repeat (8) cyc(1'b1);
      checks++;
      if (bus.state !== WRITE_STORE || en !== 4'b0100) begin
         errors++; $display("FAIL wr_dmw: state=%0d en=%b, want 7 0100", bus.state, en);
      end
      cyc(1'b0);
      checks++;
      if (bus.state !== DONE || en !== 4'b0000 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL wr_done: state=%0d en=%b busy=%b, want 8 0000 1", bus.state, en, bus.busy);
      end
      checks++;
      if (ale_n != 1 || dmw_n != 1 || pl_n != 0 || miso_n != 0) begin
         errors++; $display("FAIL wr_pulses: ale=%0d dmw=%0d pl=%0d miso=%0d, want 1 1 0 0", ale_n, dmw_n, pl_n, miso_n);
      end
      bus.chipSelect = 1'b1;
      cyc(1'b0);
      checks++;
      if (bus.state !== IDLE || bus.busy !== 1'b0) begin
         errors++; $display("FAIL wr_idle: state=%0d busy=%b, want 0 0", bus.state, bus.busy);
      end
   endtask

   task automatic test_read;
      clr_cnt();
      bus.chipSelect = 1'b0;
      cyc(1'b0);
      repeat (7) cyc(1'b1);
      bus.rwBit = SPI_READ;
      cyc(1'b1);
      checks++;
      if (bus.state !== GOT || en !== 4'b1000) begin
         errors++; $display("FAIL rd_ale: state=%0d en=%b, want 2 1000", bus.state, en);
      end
      cyc(1'b1);
      checks++;
      if (bus.state !== READ_WAIT || en !== 4'b0000) begin
         errors++; $display("FAIL rd_wait: state=%0d en=%b, want 3 0000", bus.state, en);
      end
      cyc(1'b0);
      checks++;
      if (bus.state !== READ_LOAD || en !== 4'b0010) begin
         errors++; $display("FAIL rd_load: state=%0d en=%b, want 4 0010", bus.state, en);
      end
      cyc(1'b0);
      checks++;
      if (bus.state !== READ_SEND || en !== 4'b0001 || bus.bitCount !== 3'd0) begin
         errors++; $display("FAIL rd_send: state=%0d en=%b cnt=%0d, want 5 0001 0", bus.state, en, bus.bitCount);
      end
      repeat (7) cyc(1'b1);
      checks++;
      if (en !== 4'b0001 || bus.bitCount !== 3'd7) begin
         errors++; $display("FAIL rd_send7: en=%b cnt=%0d, want 0001 7", en, bus.bitCount);
      end
      cyc(1'b1);
      checks++;
      if (bus.state !== DONE || en !== 4'b0000) begin
         errors++; $display("FAIL rd_done: state=%0d en=%b, want 8 0000", bus.state, en);
      end
      checks++;
      if (ale_n != 1 || dmw_n != 0 || pl_n != 1 || miso_n != 8) begin
         errors++; $display("FAIL rd_pulses: ale=%0d dmw=%0d pl=%0d miso=%0d, want 1 0 1 8", ale_n, dmw_n, pl_n, miso_n);
      end
      bus.chipSelect = 1'b1;
      cyc(1'b0);
   endtask

   task automatic test_abort;
      clr_cnt();
      bus.chipSelect = 1'b0;
      cyc(1'b0);
      repeat (5) cyc(1'b1);
      checks++;
      if (bus.bitCount !== 3'd5) begin
         errors++; $display("FAIL ab_count: cnt=%0d, want 5", bus.bitCount);
      end
      bus.chipSelect = 1'b1;
      cyc(1'b0);
      checks++;
      if (bus.state !== IDLE || bus.bitCount !== 3'd0 || ale_n + dmw_n + pl_n + miso_n != 0) begin
         errors++; $display("FAIL ab_idle: state=%0d cnt=%0d pulses=%0d, want 0 0 0", bus.state, bus.bitCount, ale_n + dmw_n + pl_n + miso_n);
      end
      bus.chipSelect = 1'b0;
      cyc(1'b0);
      cyc(1'b1);
      checks++;
      if (bus.state !== GET || bus.bitCount !== 3'd1) begin
         errors++; $display("FAIL ab_restart: state=%0d cnt=%0d, want 1 1", bus.state, bus.bitCount);
      end
      bus.chipSelect = 1'b1;
      cyc(1'b0);
   endtask

   task automatic test_cs_collide;
      clr_cnt();
      bus.chipSelect = 1'b0;
      cyc(1'b0);
      repeat (7) cyc(1'b1);
      bus.chipSelect = 1'b1;
      cyc(1'b1);
      checks++;
      if (bus.state !== IDLE || en !== 4'b0000 || ale_n != 0) begin
         errors++; $display("FAIL collide: state=%0d en=%b ale=%0d, want 0 0000 0", bus.state, en, ale_n);
      end
      cyc(1'b0);
      checks++;
      if (ale_n != 0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL collide_after: ale=%0d busy=%b, want 0 0", ale_n, bus.busy);
      end
   endtask

   task automatic test_done_extra;
      bus.chipSelect = 1'b0;
      bus.rwBit = SPI_WRITE;
      cyc(1'b0);
      repeat (8) cyc(1'b1);
      cyc(1'b0);
      repeat (8) cyc(1'b1);
      cyc(1'b0);
      clr_cnt();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1);
         checks++;
         if (bus.state !== DONE || en !== 4'b0000 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL done_extra%0d: state=%0d en=%b busy=%b, want 8 0000 1", i, bus.state, en, bus.busy);
         end
      end
      bus.chipSelect = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL done_busy_hold: busy=%b, want 1", bus.busy);
      end
      cyc(1'b0);
      checks++;
      if (bus.busy !== 1'b0 || bus.state !== IDLE || ale_n + dmw_n + pl_n + miso_n != 0) begin
         errors++; $display("FAIL done_release: busy=%b state=%0d pulses=%0d, want 0 0 0", bus.busy, bus.state, ale_n + dmw_n + pl_n + miso_n);
      end
   endtask

   task automatic test_reset_mid;
      bus.chipSelect = 1'b0;
      bus.rwBit = SPI_READ;
      cyc(1'b0);
      repeat (8) cyc(1'b1);
      repeat (3) cyc(1'b0);
      repeat (3) cyc(1'b1);
      checks++;
      if (bus.state !== READ_SEND || bus.bitCount !== 3'd3 || en !== 4'b0001) begin
         errors++; $display("FAIL rst_setup: state=%0d cnt=%0d en=%b, want 5 3 0001", bus.state, bus.bitCount, en);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.state !== IDLE || bus.bitCount !== 3'd0 || en !== 4'b0000 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL rst_async: state=%0d cnt=%0d en=%b busy=%b, want 0 0 0000 0", bus.state, bus.bitCount, en, bus.busy);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      cyc(1'b0);
      checks++;
      if (bus.state !== GET || bus.bitCount !== 3'd0 || bus.busy !== 1'b1) begin
         errors++; $display("FAIL rst_release: state=%0d cnt=%0d busy=%b, want 1 0 1", bus.state, bus.bitCount, bus.busy);
      end
      bus.chipSelect = 1'b1;
      cyc(1'b0);
   endtask

   initial begin
      reset = 1'b1;
      bus.sclkEdgeNeg = 1'b0;
      bus.chipSelect = 1'b1;
      bus.rwBit = 1'b0;
      @(posedge clk); #1;
      test_reset;
      reset = 1'b0;
      cyc(1'b0);
      test_write;
      test_read;
      test_abort;
      test_cs_collide;
      test_done_extra;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_fsm.md
# spi_fsm

Transaction controller for the SPI memory peripheral. It sits directly downstream of the conditioned-SCLK/CS inputs and beside the serial shift register, and it consumes that register's shifted-in command bit. It counts serial bit strobes, decodes the read/write bit, and drives the address-latch, memory-write, shift-register parallel-load and MISO tristate enables. One instance is used per SPI slave.

## Interface
- `width`, default 8: bits per SPI frame. There are two frames per transaction (command then data). The command frame is 7 address bits followed by the R/W bit.
- `clk`  in  1  FPGA clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `sclkEdgeNeg`  in  1  one-`clk`-cycle strobe per SCLK falling edge; the same strobe that shifts the shift register.
- `chipSelect`  in  1  conditioned CS, active-low; a transaction is live while 0.
- `rwBit`  in  1  shift register `parallelDataOut[0]`, the last bit shifted in; 1 = read, 0 = write.
- `addressLatchEnable`  out  1  latches `parallelDataOut` as the memory address.
- `dataMemWriteEnable`  out  1  memory write strobe.
- `parallelLoad`  out  1  shift register parallel load of memory read data.
- `misoBufferEnable`  out  1  drives MISO from `serialDataOut`; otherwise MISO is high-Z.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, GET, GOT, READ_WAIT, READ_LOAD, READ_SEND, WRITE_RECV, WRITE_STORE, DONE.
- Bit counter `bitCount` covers 0..width-1. It increments only on `sclkEdgeNeg` in GET, READ_SEND and WRITE_RECV. It clears on every state change.
- IDLE: on `chipSelect`=0, go to GET.
- GET: each strobe increments the count. A strobe at count width-1 moves to GOT.
- GOT, 1 cycle: `addressLatchEnable`=1. Then go to READ_WAIT if `rwBit`=1, else WRITE_RECV.
- READ_WAIT, 1 cycle: covers the memory read access.
- READ_LOAD, 1 cycle: `parallelLoad`=1. Then go to READ_SEND.
- READ_SEND: `misoBufferEnable`=1. A strobe at count width-1 moves to DONE.
- WRITE_RECV: counts strobes. A strobe at count width-1 moves to WRITE_STORE.
- WRITE_STORE, 1 cycle: `dataMemWriteEnable`=1. Then go to DONE.
- DONE: all enables 0, `busy`=1. Holds until `chipSelect`=1.
- From any state, `chipSelect`=1 sampled at a clock edge goes to IDLE on that edge. CS takes priority over a strobe in the same cycle: the strobe is not counted and no pulse is issued.
- Strobes in IDLE, GOT, READ_WAIT, READ_LOAD, WRITE_STORE and DONE are ignored.
- Outputs are Moore-decoded from the state register only, with no input-to-output combinational path.

## Timing
- Reset values: state IDLE, `bitCount` 0, all five outputs 0. Async assertion forces these mid-transaction without waiting for `clk`. The first transition after release happens on a `clk` edge.
- The `addressLatchEnable` pulse is exactly 1 cycle, in the cycle after the width-th command strobe. That cycle's `rwBit` is valid because the shift register updated on the same edge.
- Read path: width-th command strobe, then GOT (+1), READ_WAIT (+2), and `parallelLoad` at +3. `misoBufferEnable` rises at +4 and falls on the edge that registers the width-th data strobe.
- Write path: `dataMemWriteEnable` is a 1-cycle pulse in the cycle after the width-th data strobe.
- Each enable is a single-cycle pulse per transaction. `misoBufferEnable` is the exception and is a level.
- Back-to-back transactions need `chipSelect`=1 for at least 1 `clk` cycle between them.

## Structure
- Shared package `spi_pkg`:
  - state encoding constants (4-bit);
  - `SPI_READ`=1 / `SPI_WRITE`=0;
  - default frame width 8.
- One sub-module, `spi_bitcounter`:
  - parameter `width`;
  - inputs: `clk`, `reset`, `clear`, `inc`;
  - outputs: `count`, `last` (count==width-1).
- Everything else is in `spi_fsm`.

## Test plan
- Reset during READ_SEND at count 3: all outputs 0 immediately. After release, with CS held low, state is GET and the count is 0.
- Write transaction: 8 strobes with `rwBit`=0 at the GOT cycle, then 8 strobes. Expect `addressLatchEnable` for 1 cycle after strobe 8, `dataMemWriteEnable` for 1 cycle after strobe 16, no `parallelLoad`, and `misoBufferEnable` never high.
- Read transaction: 8 strobes with `rwBit`=1. Expect `addressLatchEnable` at +1, `parallelLoad` at +3, and `misoBufferEnable` from +4 through strobe 16. No `dataMemWriteEnable`.
- CS abort: raise CS after 5 command strobes. Expect IDLE on the next edge and no pulses. The next transaction counts from 0.
- Simultaneous CS rise and 8th command strobe: no `addressLatchEnable`; state goes to IDLE.
- Extra strobes in DONE (3 extra): no outputs. `busy` stays 1 until CS=1, then goes to 0 one cycle later.
